// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the asynchronous FIFO pointer handlers.
//   PTR_WIDTH_DEF : default address width (FIFO depth 2**PTR_WIDTH_DEF).
//   bin2gray      : binary to reflected Gray code.
//   gray2bin      : reflected Gray code to binary.
// Both functions operate on 32-bit values. Callers zero-extend narrower
// pointers and take the low bits of the result.
package fifo_pkg;

   localparam int unsigned PTR_WIDTH_DEF = 4;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // XOR prefix from the MSB down, done in log2 steps.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int s = 1; s < 32; s = s * 2) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray to binary converter.
//   W    : vector width.
//   gray : Gray-coded input.
//   bin  : binary output. Each bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
   parameter int unsigned W = 5
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end

endmodule

// File: rtl/rd_ptr_handler.sv
// rd_ptr_handler: read-domain pointer handler for the asynchronous FIFO.
// It advances the binary and Gray read pointers on accepted reads. It derives
// the empty, level, underflow and rvalid status from the Gray write pointer,
// which arrives already synchronized into i_clk.
//   i_clk, i_rstn  : clock and asynchronous active-low reset.
//   i_en           : read request. It is dropped while o_empty is high.
//   i_g_wr_ptr     : Gray write pointer, already in the read clock domain.
//   o_b_rd_addr    : binary read address. This is the current pointer.
//   o_g_rd_ptr     : registered Gray read pointer, sent to the synchronizer.
//   o_empty        : registered empty flag.
//   o_rvalid       : memory read data is valid this cycle.
//   o_rd_level     : registered entry count as seen by the read side.
//   o_underflow    : one-cycle pulse for a read requested while empty.
//   o_almost_empty : present only when RD_ALMOST_EMPTY_EN is defined. It is
//                    high when the level is at or below AE_THRESH.
module rd_ptr_handler
   import fifo_pkg::*;
#(
   parameter int unsigned PTR_WIDTH = PTR_WIDTH_DEF,
   parameter int unsigned AE_THRESH = 2
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_en,
   input  logic [PTR_WIDTH:0] i_g_wr_ptr,
   output logic [PTR_WIDTH-1:0] o_b_rd_addr,
   output logic [PTR_WIDTH:0] o_g_rd_ptr,
   output logic               o_empty,
   output logic               o_rvalid,
   output logic [PTR_WIDTH:0] o_rd_level,
   output logic               o_underflow
`ifdef RD_ALMOST_EMPTY_EN
   ,
   output logic               o_almost_empty
`endif
);

   if (AE_THRESH > (32'd1 << PTR_WIDTH)) begin : g_bad_ae_thresh
      $error("AE_THRESH exceeds FIFO depth");
   end

   logic               rd_acc;
   logic [PTR_WIDTH:0] b_rd_ptr_q;
   logic [PTR_WIDTH:0] g_rd_ptr_q;
   logic [PTR_WIDTH:0] nxt_b;
   logic [PTR_WIDTH:0] nxt_g;
   logic [PTR_WIDTH:0] wbin;
   logic [PTR_WIDTH:0] level_d;
   logic [PTR_WIDTH:0] level_q;
   logic               empty_q;
   logic               rvalid_q;
   logic               underflow_q;

   assign rd_acc = i_en & ~empty_q;
   assign nxt_b  = b_rd_ptr_q + {{PTR_WIDTH{1'b0}}, rd_acc};
   assign nxt_g  = nxt_b ^ (nxt_b >> 1);

   gray2bin_conv #(
      .W (PTR_WIDTH + 1)
   ) u_wbin (
      .gray (i_g_wr_ptr),
      .bin  (wbin)
   );

   // The write pointer lags behind the true value, so this count never
   // over-reports. The modulo subtraction handles pointer wrap.
   assign level_d = wbin - nxt_b;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         b_rd_ptr_q  <= '0;
         g_rd_ptr_q  <= '0;
         empty_q     <= 1'b1;
         rvalid_q    <= 1'b0;
         level_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         b_rd_ptr_q  <= nxt_b;
         g_rd_ptr_q  <= nxt_g;
         // A direct Gray compare against the next pointer raises empty on the
         // same edge that consumes the last entry.
         empty_q     <= (nxt_g == i_g_wr_ptr);
         rvalid_q    <= rd_acc;
         level_q     <= level_d;
         underflow_q <= i_en & empty_q;
      end
   end

`ifdef RD_ALMOST_EMPTY_EN
   logic almost_empty_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         almost_empty_q <= 1'b1;
      end else begin
         almost_empty_q <= (32'(level_d) <= AE_THRESH);
      end
   end

   assign o_almost_empty = almost_empty_q;
`endif

   assign o_b_rd_addr = b_rd_ptr_q[PTR_WIDTH-1:0];
   assign o_g_rd_ptr  = g_rd_ptr_q;
   assign o_empty     = empty_q;
   assign o_rvalid    = rvalid_q;
   assign o_rd_level  = level_q;
   assign o_underflow = underflow_q;

endmodule

// File: tb/tb_rd_ptr_handler.sv
module tb_rd_ptr_handler;

   localparam int PW  = 4;
   localparam int AET = 2;

   logic          clk;
   logic          rstn;
   logic          en;
   logic [PW:0]   g_wr_ptr;
   logic [PW-1:0] b_rd_addr;
   logic [PW:0]   g_rd_ptr;
   logic          empty;
   logic          rvalid;
   logic [PW:0]   rd_level;
   logic          underflow;
`ifdef RD_ALMOST_EMPTY_EN
   logic          almost_empty;
`endif

   rd_ptr_handler #(
      .PTR_WIDTH (PW),
      .AE_THRESH (AET)
   ) dut (
      .i_clk          (clk),
      .i_rstn         (rstn),
      .i_en           (en),
      .i_g_wr_ptr     (g_wr_ptr),
      .o_b_rd_addr    (b_rd_addr),
      .o_g_rd_ptr     (g_rd_ptr),
      .o_empty        (empty),
      .o_rvalid       (rvalid),
      .o_rd_level     (rd_level),
      .o_underflow    (underflow)
`ifdef RD_ALMOST_EMPTY_EN
      ,
      .o_almost_empty (almost_empty)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gray(input int v);
      return v ^ (v >> 1);
   endfunction

   // Model: total writes visible to the read side versus total reads accepted.
   int wr_n = 0;
   int m_rd;
   int m_level;
   bit m_empty;
   bit m_rvalid;
   bit m_under;
   bit m_ae;
   wire m_acc = en && !m_empty;

   assign g_wr_ptr = 5'(gray(wr_n % 32));

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_rd     <= 0;
         m_level  <= 0;
         m_empty  <= 1'b1;
         m_rvalid <= 1'b0;
         m_under  <= 1'b0;
         m_ae     <= 1'b1;
      end else begin
         m_rd     <= m_rd + int'(m_acc);
         m_level  <= wr_n - m_rd - int'(m_acc);
         m_empty  <= (wr_n - m_rd - int'(m_acc)) == 0;
         m_rvalid <= m_acc;
         m_under  <= en && m_empty;
         m_ae     <= (wr_n - m_rd - int'(m_acc)) <= AET;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("empty", int'(empty), int'(m_empty));
         check("level", int'(rd_level), m_level);
         check("rvalid", int'(rvalid), int'(m_rvalid));
         check("underflow", int'(underflow), int'(m_under));
         check("addr", int'(b_rd_addr), m_rd % 16);
         check("g_rd_ptr", int'(g_rd_ptr), gray(m_rd % 32));
`ifdef RD_ALMOST_EMPTY_EN
         check("almost_empty", int'(almost_empty), int'(m_ae));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      en   = 1'b0;
      #12;
      check("rst_empty", int'(empty), 1);
      check("rst_level", int'(rd_level), 0);
      check("rst_g_rd_ptr", int'(g_rd_ptr), 0);
      rstn   = 1'b1;
      chk_on = 1'b1;
      cyc();

      // 1: reads while empty are dropped and flagged
      en = 1'b1;
      repeat (3) begin
         cyc();
         check("t1_underflow", int'(underflow), 1);
         check("t1_addr", int'(b_rd_addr), 0);
         check("t1_rvalid", int'(rvalid), 0);
      end
      en = 1'b0;
      cyc();

      // 2: step the write pointer to 5, then drain it back-to-back
      wr_n = 5;
      cyc();
      check("t2_empty_low", int'(empty), 0);
      check("t2_level5", int'(rd_level), 5);
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t2_addr", int'(b_rd_addr), i);
         cyc();
         check("t2_rvalid", int'(rvalid), 1);
      end
      en = 1'b0;
      check("t2_empty_high", int'(empty), 1);
      check("t2_level0", int'(rd_level), 0);
      cyc();

      // 3: 20 interleaved writes and reads cross the wrap point
      for (int i = 0; i < 20; i++) begin
         wr_n = wr_n + 1;
         en   = 1'b0;
         cyc();
         en = 1'b1;
         cyc();
      end
      en = 1'b0;
      check("t3_addr", int'(b_rd_addr), 9);
      check("t3_g_rd_ptr", int'(g_rd_ptr), 21);
      cyc();

      // 4: the last read and a new write arrive in the same cycle
      wr_n = wr_n + 1;
      cyc();
      check("t4_level1", int'(rd_level), 1);
      en   = 1'b1;
      wr_n = wr_n + 1;
      cyc();
      en = 1'b0;
      check("t4_empty", int'(empty), 0);
      check("t4_level", int'(rd_level), 1);

      // 5: fill to 4, then read down to empty
      wr_n = wr_n + 3;
      cyc();
      check("t5_level4", int'(rd_level), 4);
`ifdef RD_ALMOST_EMPTY_EN
      check("t5_ae4", int'(almost_empty), 0);
`endif
      en = 1'b1;
      for (int lv = 3; lv >= 0; lv--) begin
         cyc();
         check("t5_level", int'(rd_level), lv);
`ifdef RD_ALMOST_EMPTY_EN
         check("t5_ae", int'(almost_empty), int'(lv <= AET));
`endif
      end
      en = 1'b0;
      cyc();

      // 6: asynchronous reset in the middle of a burst at level 6
      wr_n = wr_n + 6;
      cyc();
      check("t6_level6", int'(rd_level), 6);
      en = 1'b1;
      cyc();
      check("t6_rvalid_pre", int'(rvalid), 1);
      #2;
      rstn = 1'b0;
      wr_n = 0;
      en   = 1'b0;
      #1;
      check("t6_rvalid", int'(rvalid), 0);
      check("t6_empty", int'(empty), 1);
      check("t6_level", int'(rd_level), 0);
      check("t6_g_rd_ptr", int'(g_rd_ptr), 0);
      check("t6_addr", int'(b_rd_addr), 0);
      check("t6_underflow", int'(underflow), 0);
`ifdef RD_ALMOST_EMPTY_EN
      check("t6_ae", int'(almost_empty), 1);
`endif
      cyc();
      rstn = 1'b1;
      cyc();
      cyc();
      chk_on = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
